// File: rtl/leaky_act_pipe.sv
// leaky_act_pipe: multi-lane activation stage, two-register valid/ready pipeline.
//
// Each beat carries LANES signed DATA_WIDTH elements plus a per-beat activation
// mode and leak shift. Mode and shift travel with the beat, so they can change
// every beat without flushing the pipeline.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   in_valid        input beat valid
//   in_ready        block can accept a beat (combinational from out_ready)
//   in_data         LANES x DATA_WIDTH, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_mode         0 BYPASS, 1 RELU, 2 LEAKY, 3 RELU6
//   in_alpha_shift  arithmetic right shift applied to negative lanes in LEAKY
//   out_valid       output beat valid
//   out_ready       downstream accepts
//   out_data        result, same lane packing as in_data
//
// Optional build macro LEAKY_ACT_STATS_EN adds:
//   stat_clear      synchronous clear of the counter (wins over increment)
//   stat_neg_count  saturating count of negative lanes over accepted beats
module leaky_act_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [1:0]                  in_mode,
  input  logic [SHIFT_WIDTH-1:0]      in_alpha_shift,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data
`ifdef LEAKY_ACT_STATS_EN
  ,
  input  logic                        stat_clear,
  output logic [31:0]                 stat_neg_count
`endif
);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_RELU6  = 2'd3
  } mode_e;

  // 6.0 in the fixed-point format, clamped to the largest positive value when
  // it does not fit.
  localparam logic [63:0] C6_WIDE = 64'd6 << FRAC_WIDTH;
  localparam logic [63:0] POS_MAX = (64'd1 << (DATA_WIDTH - 1)) - 64'd1;
  localparam logic signed [DATA_WIDTH-1:0] C6 =
    (C6_WIDE > POS_MAX) ? POS_MAX[DATA_WIDTH-1:0] : C6_WIDE[DATA_WIDTH-1:0];

  function automatic logic signed [DATA_WIDTH-1:0] act_lane(
    input logic signed [DATA_WIDTH-1:0] x,
    input mode_e                        m,
    input logic [SHIFT_WIDTH-1:0]       sh
  );
    logic signed [DATA_WIDTH-1:0] y;
    y = x;
    case (m)
      MODE_BYPASS: y = x;
      MODE_RELU:   y = x[DATA_WIDTH-1] ? '0 : x;
      // >>> floors, so small negatives settle at -1 rather than 0.
      MODE_LEAKY:  y = x[DATA_WIDTH-1] ? (x >>> sh) : x;
      MODE_RELU6:  y = x[DATA_WIDTH-1] ? '0 : ((x > C6) ? C6 : x);
      default:     y = x;
    endcase
    return y;
  endfunction

  logic                        s1_valid;
  logic [LANES*DATA_WIDTH-1:0] s1_data;
  mode_e                       s1_mode;
  logic [SHIFT_WIDTH-1:0]      s1_shift;

  logic                        s2_valid;
  logic [LANES*DATA_WIDTH-1:0] s2_data;

  logic                        s1_load;
  logic                        s2_load;
  logic [LANES*DATA_WIDTH-1:0] s1_result;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  always_comb begin
    s1_result = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      s1_result[i*DATA_WIDTH +: DATA_WIDTH] =
        act_lane(s1_data[i*DATA_WIDTH +: DATA_WIDTH], s1_mode, s1_shift);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_BYPASS;
      s1_shift <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data  <= in_data;
        s1_mode  <= mode_e'(in_mode);
        s1_shift <= in_alpha_shift;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s1_result;
      end
    end
  end

`ifdef LEAKY_ACT_STATS_EN
  localparam int CNT_W = $clog2(LANES + 1);

  logic [CNT_W-1:0] neg_lanes;
  logic [32:0]      stat_sum;
  logic [31:0]      stat_cnt;

  always_comb begin
    neg_lanes = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      neg_lanes = neg_lanes + CNT_W'(in_data[i*DATA_WIDTH + DATA_WIDTH - 1]);
    end
  end

  assign stat_sum       = {1'b0, stat_cnt} + 33'(neg_lanes);
  assign stat_neg_count = stat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt <= '0;
    end else if (stat_clear) begin
      stat_cnt <= '0;
    end else if (in_valid && in_ready) begin
      stat_cnt <= stat_sum[32] ? '1 : stat_sum[31:0];
    end
  end
`endif

endmodule
